// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control path: FSM states, ALU op codes,
// instruction field constants, operand-select codes and halt causes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_ALU_WB    = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WRITE = 4'd7,
    S_MEM_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_HALT      = 4'd10
  } state_e;

  // Codes must match the ALU's own operation select.
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_XOR = 3'd2,
    ALU_SLL = 3'd3,
    ALU_BNE = 3'd4
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_I       = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_ILLEGAL = 3'd5
  } op_class_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BNE  = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_OLDPC = 2'd1;
  localparam logic [1:0] SRC_A_RS1   = 2'd2;
  localparam logic [1:0] SRC_B_RS2   = 2'd0;
  localparam logic [1:0] SRC_B_FOUR  = 2'd1;
  localparam logic [1:0] SRC_B_IMM   = 2'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  function automatic logic [6:0] opcode_of(input logic [31:0] instr);
    return instr[6:0];
  endfunction

  function automatic logic [2:0] funct3_of(input logic [31:0] instr);
    return instr[14:12];
  endfunction

  function automatic logic [6:0] funct7_of(input logic [31:0] instr);
    return instr[31:25];
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction classifier: opcode class, ALU operation and a
// full legality flag (opcode plus funct fields).
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic [2:0]  op_class,
  output logic [2:0]  alu_ctrl,
  output logic        legal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode        = opcode_of(instr);
  assign funct3        = funct3_of(instr);
  assign funct7        = funct7_of(instr);
  // Register indices and immediates belong to the datapath, not to control.
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    op_class = CLS_ILLEGAL;
    alu_ctrl = ALU_ADD;
    legal    = 1'b0;
    case (opcode)
      OPC_R: begin
        op_class = CLS_R;
        case ({funct7, funct3})
          {F7_BASE, F3_ADD}: begin alu_ctrl = ALU_ADD; legal = 1'b1; end
          {F7_ALT,  F3_ADD}: begin alu_ctrl = ALU_SUB; legal = 1'b1; end
          {F7_BASE, F3_XOR}: begin alu_ctrl = ALU_XOR; legal = 1'b1; end
          {F7_BASE, F3_SLL}: begin alu_ctrl = ALU_SLL; legal = 1'b1; end
          default:           begin alu_ctrl = ALU_ADD; legal = 1'b0; end
        endcase
      end
      OPC_I: begin
        op_class = CLS_I;
        legal    = (funct3 == F3_ADD);
      end
      OPC_LOAD: begin
        op_class = CLS_LOAD;
        legal    = (funct3 == F3_WORD);
      end
      OPC_STORE: begin
        op_class = CLS_STORE;
        legal    = (funct3 == F3_WORD);
      end
      OPC_BRANCH: begin
        op_class = CLS_BRANCH;
        alu_ctrl = ALU_BNE;
        legal    = (funct3 == F3_BNE);
      end
      default: begin
        op_class = CLS_ILLEGAL;
        legal    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback,
// drives ALU selects and datapath enables, halts on illegal code or bus timeout.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_en,
  output logic        pc_src,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_ctrl,
  output logic        halted,
  output logic [1:0]  halt_cause,
  output logic [3:0]  state
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e           state_r;
  state_e           next_state_s;
  logic [CNT_W-1:0] wait_cnt_r;
  logic [2:0]       dec_class_s;
  logic [2:0]       dec_alu_s;
  logic             dec_legal_s;
  logic             done_s;
  logic             timeout_s;
  logic             fetch_done_s;
  logic             branch_taken_s;
  logic [1:0]       cause_s;

  instr_decoder u_decoder (
    .instr    (instr),
    .op_class (dec_class_s),
    .alu_ctrl (dec_alu_s),
    .legal    (dec_legal_s)
  );

  // mem_req is registered, so it is only high in an armed request cycle.
  assign done_s         = mem_req & mem_ready;
  assign timeout_s      = mem_req & ~mem_ready & (wait_cnt_r == CNT_LAST);
  assign fetch_done_s   = (state_r == S_FETCH) & done_s;
  assign branch_taken_s = (state_r == S_BRANCH) & dec_legal_s & ~alu_zero;
  assign ir_write       = ~rst & fetch_done_s;
  assign pc_en          = ~rst & (fetch_done_s | branch_taken_s);
  assign cause_s        = timeout_s ? CAUSE_TIMEOUT : CAUSE_ILLEGAL;
  assign state          = state_r;

  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (done_s)         next_state_s = S_DECODE;
        else if (timeout_s) next_state_s = S_HALT;
        else                next_state_s = S_FETCH;
      end
      S_DECODE: begin
        case (dec_class_s)
          CLS_R:               next_state_s = S_EXEC_R;
          CLS_I:               next_state_s = S_EXEC_I;
          CLS_LOAD, CLS_STORE: next_state_s = S_MEM_ADDR;
          CLS_BRANCH:          next_state_s = S_BRANCH;
          default:             next_state_s = S_HALT;
        endcase
      end
      S_EXEC_R, S_EXEC_I: begin
        if (dec_legal_s) next_state_s = S_ALU_WB;
        else             next_state_s = S_HALT;
      end
      S_ALU_WB: next_state_s = S_FETCH;
      S_MEM_ADDR: begin
        if (!dec_legal_s)                 next_state_s = S_HALT;
        else if (dec_class_s == CLS_STORE) next_state_s = S_MEM_WRITE;
        else                              next_state_s = S_MEM_READ;
      end
      S_MEM_READ: begin
        if (done_s)         next_state_s = S_MEM_WB;
        else if (timeout_s) next_state_s = S_HALT;
        else                next_state_s = S_MEM_READ;
      end
      S_MEM_WRITE: begin
        if (done_s)         next_state_s = S_FETCH;
        else if (timeout_s) next_state_s = S_HALT;
        else                next_state_s = S_MEM_WRITE;
      end
      S_MEM_WB: next_state_s = S_FETCH;
      S_BRANCH: begin
        if (dec_legal_s) next_state_s = S_FETCH;
        else             next_state_s = S_HALT;
      end
      S_HALT:  next_state_s = S_HALT;
      default: next_state_s = S_HALT;
    endcase
  end

  // State, wait counter and Moore outputs, decoded one cycle early from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_FETCH;
      wait_cnt_r <= {CNT_W{1'b0}};
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      iord       <= 1'b0;
      pc_src     <= 1'b0;
      reg_write  <= 1'b0;
      mem_to_reg <= 1'b0;
      alu_src_a  <= SRC_A_PC;
      alu_src_b  <= SRC_B_RS2;
      alu_ctrl   <= ALU_ADD;
      halted     <= 1'b0;
      halt_cause <= CAUSE_NONE;
    end else begin
      state_r <= next_state_s;

      if (mem_req && !mem_ready && !timeout_s) wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      else                                     wait_cnt_r <= {CNT_W{1'b0}};

      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      iord       <= 1'b0;
      pc_src     <= 1'b0;
      reg_write  <= 1'b0;
      mem_to_reg <= 1'b0;
      alu_src_a  <= SRC_A_PC;
      alu_src_b  <= SRC_B_RS2;
      alu_ctrl   <= ALU_ADD;
      halted     <= 1'b0;
      case (next_state_s)
        S_FETCH: begin
          mem_req   <= 1'b1;
          alu_src_a <= SRC_A_PC;
          alu_src_b <= SRC_B_FOUR;
        end
        S_DECODE: begin
          alu_src_a <= SRC_A_OLDPC;
          alu_src_b <= SRC_B_IMM;
        end
        S_EXEC_R: begin
          alu_src_a <= SRC_A_RS1;
          alu_src_b <= SRC_B_RS2;
          alu_ctrl  <= dec_alu_s;
        end
        S_EXEC_I, S_MEM_ADDR: begin
          alu_src_a <= SRC_A_RS1;
          alu_src_b <= SRC_B_IMM;
        end
        S_ALU_WB: reg_write <= 1'b1;
        S_MEM_READ: begin
          mem_req <= 1'b1;
          iord    <= 1'b1;
        end
        S_MEM_WRITE: begin
          mem_req <= 1'b1;
          iord    <= 1'b1;
          mem_we  <= 1'b1;
        end
        S_MEM_WB: begin
          reg_write  <= 1'b1;
          mem_to_reg <= 1'b1;
        end
        S_BRANCH: begin
          alu_src_a <= SRC_A_RS1;
          alu_src_b <= SRC_B_RS2;
          alu_ctrl  <= ALU_BNE;
          pc_src    <= 1'b1;
        end
        S_HALT:  halted <= 1'b1;
        default: halted <= 1'b0;
      endcase

      // Cause is captured on HALT entry and then frozen until reset.
      if (next_state_s != S_HALT) halt_cause <= CAUSE_NONE;
      else if (state_r != S_HALT) halt_cause <= cause_s;
      else                        halt_cause <= halt_cause;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench: per-instruction expected cycle sequences built
// from the instruction kind are compared against every DUT output each cycle.
module tb_multicycle_control;
  import ctrl_pkg::*;

  localparam int T = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, iord, ir_write, pc_en, pc_src, reg_write, mem_to_reg;
  logic [1:0]  alu_src_a, alu_src_b, halt_cause;
  logic [2:0]  alu_ctrl;
  logic        halted;
  logic [3:0]  state;

  multicycle_control #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_en(pc_en),
    .pc_src(pc_src), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .halted(halted), .halt_cause(halt_cause),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef enum int {K_ADD, K_SUB, K_XOR, K_SLL, K_ADDI, K_LW, K_SW, K_BNE,
                    K_BADOP, K_BADF3, K_BADI} kind_e;

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] cause;
    logic       halted;
    logic [2:0] alu;
    logic [1:0] b;
    logic [1:0] a;
    logic       m2r;
    logic       rw;
    logic       pcsrc;
    logic       pcen;
    logic       irw;
    logic       iord;
    logic       we;
    logic       req;
  } exp_t;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] cur_instr = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %06h expected %06h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t observed();
    exp_t o;
    o.st = state; o.cause = halt_cause; o.halted = halted; o.alu = alu_ctrl;
    o.b = alu_src_b; o.a = alu_src_a; o.m2r = mem_to_reg; o.rw = reg_write;
    o.pcsrc = pc_src; o.pcen = pc_en; o.irw = ir_write; o.iord = iord;
    o.we = mem_we; o.req = mem_req;
    return o;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected output vectors per control step, straight from the behaviour table.
  function automatic exp_t blank(input state_e s);
    exp_t e;
    e = '0;
    e.st = s;
    return e;
  endfunction

  function automatic exp_t e_fetch(input logic rdy);
    exp_t e = blank(S_FETCH);
    e.req = 1'b1; e.b = 2'd1; e.irw = rdy; e.pcen = rdy;
    return e;
  endfunction

  function automatic exp_t e_decode();
    exp_t e = blank(S_DECODE);
    e.a = 2'd1; e.b = 2'd2;
    return e;
  endfunction

  function automatic exp_t e_exec(input state_e s, input logic [1:0] b, input logic [2:0] alu);
    exp_t e = blank(s);
    e.a = 2'd2; e.b = b; e.alu = alu;
    return e;
  endfunction

  function automatic exp_t e_wb(input state_e s, input logic m2r);
    exp_t e = blank(s);
    e.rw = 1'b1; e.m2r = m2r;
    return e;
  endfunction

  function automatic exp_t e_mem(input state_e s, input logic we);
    exp_t e = blank(s);
    e.req = 1'b1; e.iord = 1'b1; e.we = we;
    return e;
  endfunction

  function automatic exp_t e_branch(input logic z);
    exp_t e = blank(S_BRANCH);
    e.a = 2'd2; e.b = 2'd0; e.alu = 3'd4; e.pcsrc = 1'b1; e.pcen = ~z;
    return e;
  endfunction

  function automatic exp_t e_halt(input logic [1:0] c);
    exp_t e = blank(S_HALT);
    e.halted = 1'b1; e.cause = c;
    return e;
  endfunction

  task automatic step(input exp_t e, input logic rdy, input logic z, input string tag);
    @(negedge clk);
    instr = cur_instr; mem_ready = rdy; alu_zero = z;
    #1;
    check(tag, {10'd0, observed()}, {10'd0, e});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; mem_ready = rb(); alu_zero = rb();
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check("rst_hold", {10'd0, observed()}, {10'd0, blank(S_FETCH)});
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b1;
    #1;
    check("rst_release", {10'd0, observed()}, {10'd0, blank(S_FETCH)});
  endtask

  task automatic do_fetch(input int w);
    for (int i = 0; i < w; i++) step(e_fetch(1'b0), 1'b0, rb(), "fetch_wait");
    step(e_fetch(1'b1), 1'b1, rb(), "fetch_done");
  endtask

  task automatic mem_phase(input state_e s, input logic we, input int w);
    for (int i = 0; i < w; i++) step(e_mem(s, we), 1'b0, rb(), "mem_wait");
    step(e_mem(s, we), 1'b1, rb(), "mem_done");
  endtask

  task automatic halt_phase(input logic [1:0] c, input int n);
    for (int i = 0; i < n; i++) step(e_halt(c), rb(), rb(), "halt");
  endtask

  function automatic logic [31:0] mk_instr(input kind_e k);
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [6:0]  bad_ops [4];
    rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
    f3  = 3'($urandom_range(0, 7));
    bad_ops = '{7'b1111111, 7'b0110111, 7'b1101111, 7'b0000000};
    case (k)
      K_ADD:   return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      K_SUB:   return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      K_XOR:   return {7'b0000000, rs2, rs1, 3'b100, rd, 7'b0110011};
      K_SLL:   return {7'b0000000, rs2, rs1, 3'b001, rd, 7'b0110011};
      K_ADDI:  return {12'($urandom), rs1, 3'b000, rd, 7'b0010011};
      K_LW:    return {12'($urandom), rs1, 3'b010, rd, 7'b0000011};
      K_SW:    return {7'($urandom), rs2, rs1, 3'b010, 5'($urandom), 7'b0100011};
      K_BNE:   return {7'($urandom), rs2, rs1, 3'b001, 5'($urandom), 7'b1100011};
      K_BADOP: return {25'($urandom), bad_ops[$urandom_range(0, 3)]};
      K_BADF3: return {12'($urandom), rs1, (f3 == 3'b010) ? 3'b011 : f3, rd, 7'b0000011};
      K_BADI:  return {12'($urandom), rs1, (f3 == 3'b000) ? 3'b001 : f3, rd, 7'b0010011};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic run_instr(input kind_e k, input logic [31:0] ins, input int fw, input int mw,
                           input logic z);
    cur_instr = ins;
    do_fetch(fw);
    step(e_decode(), rb(), rb(), "decode");
    case (k)
      K_ADD, K_SUB, K_XOR, K_SLL: begin
        step(e_exec(S_EXEC_R, 2'd0, (k == K_ADD) ? 3'd0 : (k == K_SUB) ? 3'd1 :
                                    (k == K_XOR) ? 3'd2 : 3'd3), rb(), rb(), "exec_r");
        step(e_wb(S_ALU_WB, 1'b0), rb(), rb(), "alu_wb");
      end
      K_ADDI: begin
        step(e_exec(S_EXEC_I, 2'd2, 3'd0), rb(), rb(), "exec_i");
        step(e_wb(S_ALU_WB, 1'b0), rb(), rb(), "alu_wb");
      end
      K_LW: begin
        step(e_exec(S_MEM_ADDR, 2'd2, 3'd0), rb(), rb(), "mem_addr");
        mem_phase(S_MEM_READ, 1'b0, mw);
        step(e_wb(S_MEM_WB, 1'b1), rb(), rb(), "mem_wb");
      end
      K_SW: begin
        step(e_exec(S_MEM_ADDR, 2'd2, 3'd0), rb(), rb(), "mem_addr");
        mem_phase(S_MEM_WRITE, 1'b1, mw);
      end
      K_BNE: step(e_branch(z), rb(), z, "branch");
      K_BADOP: begin
        halt_phase(2'd1, 3);
        do_reset();
      end
      K_BADF3: begin
        step(e_exec(S_MEM_ADDR, 2'd2, 3'd0), rb(), rb(), "mem_addr");
        halt_phase(2'd1, 3);
        do_reset();
      end
      K_BADI: begin
        step(e_exec(S_EXEC_I, 2'd2, 3'd0), rb(), rb(), "exec_i");
        halt_phase(2'd1, 3);
        do_reset();
      end
      default: check("bad_kind", 32'(k), 32'(K_ADD));
    endcase
  endtask

  initial begin
    kind_e k;
    do_reset();

    run_instr(K_ADD, 32'h002081B3, 2, 0, 1'b0);
    run_instr(K_SUB, 32'h402081B3, 0, 0, 1'b0);
    run_instr(K_XOR, 32'h0020C1B3, 0, 0, 1'b0);
    run_instr(K_SLL, 32'h002091B3, 1, 0, 1'b0);
    run_instr(K_BNE, 32'h00209463, 0, 0, 1'b0);
    run_instr(K_BNE, 32'h00209463, 0, 0, 1'b1);
    run_instr(K_LW,  32'h0000A183, 1, 2, 1'b0);
    run_instr(K_SW,  32'h0020A023, 0, 1, 1'b0);
    run_instr(K_ADDI, 32'h00508093, 0, 0, 1'b0);

    // Reset while a load is waiting on memory.
    cur_instr = 32'h0000A183;
    do_fetch(0);
    step(e_decode(), rb(), rb(), "decode");
    step(e_exec(S_MEM_ADDR, 2'd2, 3'd0), rb(), rb(), "mem_addr");
    step(e_mem(S_MEM_READ, 1'b0), 1'b0, rb(), "read_wait");
    do_reset();

    // Completion on the last allowed cycle beats the timeout.
    run_instr(K_ADD, 32'h002081B3, T - 1, 0, 1'b0);
    run_instr(K_LW,  32'h0000A183, 0, T - 1, 1'b0);

    run_instr(K_BADOP, 32'hFFFFFFFF, 0, 0, 1'b0);

    // Fetch never answered: bus-timeout halt.
    cur_instr = 32'h002081B3;
    for (int i = 0; i < T; i++) step(e_fetch(1'b0), 1'b0, rb(), "fetch_timeout");
    halt_phase(2'd2, 4);
    do_reset();

    for (int n = 0; n < 400; n++) begin
      k = kind_e'($urandom_range(0, 10));
      run_instr(k, mk_instr(k), $urandom_range(0, 3), $urandom_range(0, 3), rb());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
